// File: rtl/snn_input_loader.sv
// rtl/snn_input_loader.sv - UART image loader, snn_core launcher and ASCII result sender
// Optional feature: define SNN_LOADER_TIMEOUT_EN to abandon partial images after TIMEOUT_CYC idle cycles.
module snn_input_loader #(
  parameter logic [23:0] TIMEOUT_CYC = 24'd5_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_rdy,
  input  logic [7:0] rx_data,
  input  logic [9:0] addr_input_unit,
  output logic       q_input,
  output logic       start,
  input  logic       done,
  input  logic [3:0] digit,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic [3:0] led
);

  typedef enum logic [1:0] {LOAD, KICK, WAIT_DONE, SEND} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [6:0] byte_cnt;
  logic [3:0] result;
  logic [7:0] pix_mem [0:97];
  logic [6:0] rd_byte;
  logic       load_wr;
  logic       byte_last;

  // Bytes are only accepted while loading; everything else on rx is dropped.
  assign load_wr   = (state == LOAD) && rx_rdy;
  assign byte_last = (byte_cnt == 7'd97);
  assign rd_byte   = addr_input_unit[9:3];

  // Next-state decode for the load / kick / wait / send cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:      if (load_wr && byte_last) state_nxt = KICK;
      KICK:      state_nxt = WAIT_DONE;
      WAIT_DONE: if (done) state_nxt = SEND;
      SEND:      if (!tx_busy) state_nxt = LOAD;
      default:   state_nxt = LOAD;
    endcase
  end

  // State register plus registered start/tx pulses and the result latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= LOAD;
      start    <= 1'b0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      led      <= 4'h0;
      result   <= 4'h0;
    end else begin
      state    <= state_nxt;
      start    <= (state == KICK);
      tx_start <= 1'b0;
      if (state == WAIT_DONE && done) begin
        result <= digit;
        led    <= digit;
      end
      if (state == SEND && !tx_busy) begin
        tx_start <= 1'b1;
        tx_data  <= 8'h30 + {4'h0, result};
      end
    end
  end

`ifdef SNN_LOADER_TIMEOUT_EN
  logic [23:0] gap_cnt;

  // Byte counter with idle-gap watchdog that restarts a stalled image at byte 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= 7'd0;
      gap_cnt  <= 24'd0;
    end else if (load_wr) begin
      byte_cnt <= byte_last ? 7'd0 : byte_cnt + 7'd1;
      gap_cnt  <= 24'd0;
    end else if (state == LOAD && byte_cnt != 7'd0) begin
      if (gap_cnt + 24'd1 >= TIMEOUT_CYC) begin
        byte_cnt <= 7'd0;
        gap_cnt  <= 24'd0;
      end else begin
        gap_cnt <= gap_cnt + 24'd1;
      end
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;

  // Byte counter; a partial image simply waits for the rest of its bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= 7'd0;
    end else if (load_wr) begin
      byte_cnt <= byte_last ? 7'd0 : byte_cnt + 7'd1;
    end
  end
`endif

  // Pixel store kept byte-wide: one rx byte is one row entry, bit k is pixel 8*n+k.
  always_ff @(posedge clk) begin
    if (load_wr) pix_mem[byte_cnt] <= rx_data;
    q_input <= (rd_byte < 7'd98) ? pix_mem[rd_byte][addr_input_unit[2:0]] : 1'b0;
  end

endmodule
